// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with parity, sticky errors and a FWFT FIFO.
// Optional macro UART_RX_MAJORITY_EN: 3-sample majority vote per bit.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int OSR    = 4,
  parameter int PARITY = 1,
  parameter int DEPTH  = 4
) (
  input  logic                       rxclk,
  input  logic                       reset_n,
  input  logic                       rx_in,
  input  logic                       rx_enable,
  output logic [DATA_W-1:0]          rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun,
  input  logic                       err_clr
);

  localparam int CW = $clog2(OSR);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP = OSR/2 + 1;
`else
  localparam int SAMP = OSR/2;
`endif
  localparam logic [CW-1:0] C_SAMP = CW'(SAMP);
  localparam logic [CW-1:0] C_LAST = CW'(OSR-1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W-1);
  localparam logic          ODD    = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, WAIT_HIGH
  } state_t;

  logic              r_rx_d1, r_rx_d2;
  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [BW-1:0]     r_bit, w_bit_nxt;
  logic [DATA_W-1:0] r_rx_reg, w_reg_nxt;
  logic              r_par_bad, w_par_bad_nxt;
  logic              w_sample, w_bit;
  logic              w_push_req, w_fe_set, w_pe_set;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr, r_rd;
  logic [LW-1:0]     r_level;
  logic              w_full, w_pop, w_push, w_ov_set;
  logic              r_fe, r_pe, r_ov;

  // two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_d1 <= 1'b1;
      r_rx_d2 <= 1'b1;
    end else begin
      r_rx_d1 <= rx_in;
      r_rx_d2 <= r_rx_d1;
    end
  end

  assign w_sample = (r_cnt == C_SAMP);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_maj;

  // capture the two samples preceding the decision point
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_maj <= 2'b11;
    end else begin
      if (r_cnt == CW'(OSR/2 - 1)) r_maj[0] <= r_rx_d2;
      if (r_cnt == CW'(OSR/2))     r_maj[1] <= r_rx_d2;
    end
  end

  assign w_bit = (r_maj[0] & r_maj[1]) |
                 (r_maj[0] & r_rx_d2) |
                 (r_maj[1] & r_rx_d2);
`else
  assign w_bit = r_rx_d2;
`endif

  // receiver next-state, bit assembly and frame verdict
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
    w_bit_nxt     = r_bit;
    w_reg_nxt     = r_rx_reg;
    w_par_bad_nxt = r_par_bad;
    w_push_req    = 1'b0;
    w_fe_set      = 1'b0;
    w_pe_set      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (rx_enable && !r_rx_d2) begin
          w_state_nxt = START;
          w_cnt_nxt   = CW'(1);
        end
      end
      START: begin
        if (w_sample) begin
          if (!w_bit) begin
            w_state_nxt   = DATA;
            w_bit_nxt     = '0;
            w_par_bad_nxt = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_sample) begin
          w_reg_nxt[r_bit] = w_bit;
          if (r_bit == B_LAST) begin
            w_state_nxt = (PARITY != 0) ? PAR : STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      PAR: begin
        if (w_sample) begin
          w_par_bad_nxt = (w_bit != ((^r_rx_reg) ^ ODD));
          w_state_nxt   = STOP;
        end
      end
      STOP: begin
        if (w_sample) begin
          if (w_bit) begin
            w_state_nxt = IDLE;
            if (r_par_bad) w_pe_set = 1'b1;
            else           w_push_req = 1'b1;
          end else begin
            w_state_nxt = WAIT_HIGH;
            w_fe_set    = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (r_rx_d2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!rx_enable) begin
      w_state_nxt = IDLE;
      w_push_req  = 1'b0;
      w_fe_set    = 1'b0;
      w_pe_set    = 1'b0;
    end
  end

  // receiver state registers
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_rx_reg  <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_rx_reg  <= w_reg_nxt;
      r_par_bad <= w_par_bad_nxt;
    end
  end

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_pop    = rx_valid & rx_ready;
  assign w_push   = w_push_req & (~w_full | w_pop);
  assign w_ov_set = w_push_req & w_full & ~w_pop;

  // FIFO storage; a pop in the same cycle frees the slot for a push
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= r_rx_reg;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // sticky error flags, a new event beats a clear
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_fe <= 1'b0;
      r_pe <= 1'b0;
      r_ov <= 1'b0;
    end else begin
      r_fe <= w_fe_set | (r_fe & ~err_clr);
      r_pe <= w_pe_set | (r_pe & ~err_clr);
      r_ov <= w_ov_set | (r_ov & ~err_clr);
    end
  end

  assign rx_data    = r_mem[r_rd];
  assign rx_valid   = (r_level != '0);
  assign level      = r_level;
  assign frame_err  = r_fe;
  assign parity_err = r_pe;
  assign overrun    = r_ov;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with oversampled bit recovery, configurable data width and parity mode, and a first-word-fall-through receive FIFO with a valid/ready read interface. It replaces the fixed 2-bit receiver in the serial input path and adds parity checking, sticky error status and buffering so downstream logic can absorb back-to-back frames.

## Interface
- `DATA_W`, 8: data bits per frame, 1..16, sent LSB first.
- `OSR`, 4: `rxclk` cycles per bit, even, ≥4.
- `PARITY`, 1: 0 = none, 1 = even, 2 = odd.
- `DEPTH`, 4: FIFO entries, power of 2, ≥2.
- `rxclk`, in, 1: sole clock; all logic on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `rx_in`, in, 1: asynchronous serial line, idle high.
- `rx_enable`, in, 1: receiver enable.
- `rx_data`, out, `DATA_W`: FIFO head word.
- `rx_valid`, out, 1: FIFO not empty.
- `rx_ready`, in, 1: consumer accepts `rx_data`.
- `level`, out, clog2(`DEPTH`+1): current FIFO occupancy.
- `frame_err`, out, 1: sticky flag; a stop bit was sampled as 0.
- `parity_err`, out, 1: sticky flag; parity mismatch.
- `overrun`, out, 1: sticky flag; a good word was dropped because the FIFO was full.
- `err_clr`, in, 1: clears all three sticky flags.

## Operation
- Synchronizer: `rx_d1`/`rx_d2` two-flop chain, both reset to 1. All decisions use `rx_d2`.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH. Reset state is IDLE.
- IDLE → START when `rx_enable` is high and `rx_d2` is 0. The bit counter `cnt` is set to 1.
- START: at `cnt` = `OSR`/2, sample the line.
  - Sample 0: go to DATA, with the bit index at 0.
  - Sample 1: false start; return to IDLE.
- DATA, PAR, STOP: sample every `OSR` cycles. `cnt` wraps `OSR`-1 → 0.
- DATA: bit *i* is shifted into `rx_reg[i]`. After bit `DATA_W`-1, go to PAR if `PARITY`≠0, otherwise STOP.
- PAR: expected parity bit = XOR of the data bits, inverted when odd parity is selected.
- STOP sample = 1 and parity OK:
  - Push `rx_reg` if the FIFO is not full; otherwise set `overrun` and drop the word.
  - Go to IDLE.
- STOP sample = 1 and parity bad: set `parity_err`, discard the word, go to IDLE.
- STOP sample = 0: set `frame_err`, discard the word, go to WAIT_HIGH.
- WAIT_HIGH → IDLE once `rx_d2` = 1. This covers break conditions.
- `rx_enable` low: the FSM is forced to IDLE next cycle and any partial frame is discarded. The FIFO and flags are unaffected and remain readable.
- FIFO is first-word-fall-through.
  - A pop occurs when `rx_valid` and `rx_ready` are both high.
  - Push and pop in the same cycle are both performed, including when full: the pop frees a slot and the push is accepted, with no overrun.
  - Pointers are clog2(`DEPTH`) bits and wrap naturally.
- Sticky flags: if set and `err_clr` occur in the same cycle, set wins.
- Reset values:
  - `rx_valid`=0, `level`=0, `rx_data`=0.
  - All flags 0.
  - FIFO pointers 0, FSM in IDLE.

## Timing
- Reference point: cycle T is the first edge at which IDLE sees `rx_d2`=0, which is 2 cycles after `rx_in` falls.
- Start sample at T+`OSR`/2.
- Data bit *i* sampled at T+`OSR`/2+(*i*+1)·`OSR`.
- Stop sampled at S = T+`OSR`/2+(`DATA_W`+P+1)·`OSR`, where P=1 if parity is enabled.
- FIFO write and flag set occur at edge S. `rx_valid`/`level` update at S+1.
- A pop updates `rx_data`, `rx_valid` and `level` in the cycle after the handshake.
- Back-to-back frames: a new start can be detected at S+1. Line timing gives half a bit of margin.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit (including start and stop) is the majority of `rx_d2` at `cnt` = `OSR`/2-1, `OSR`/2 and `OSR`/2+1.
  - The decision is made at `OSR`/2+1.
  - All sample points in Timing shift by +1 cycle.
- `UART_RX_MAJORITY_EN` undefined: single sample at `cnt` = `OSR`/2.

## Test plan
All scenarios use the default parameters (`DATA_W`=8, `OSR`=4, `PARITY`=1 even, `DEPTH`=4) unless stated.
- Send 0xA5 with parity bit 0 and stop 1, with `rx_ready`=0.
  - `rx_valid`=1 at S+1, `rx_data`=0xA5, `level`=1, all flags 0.
  - Then pulse `rx_ready`: `rx_valid`=0 and `level`=0 the next cycle.
- Pull `rx_in` low for 1 cycle only.
  - FSM returns to IDLE via the false-start path; `level` stays 0 and no flags are set.
- Send 0x01 with parity bit 0 (wrong).
  - `parity_err`=1 and `level` unchanged.
  - `err_clr` for 1 cycle then clears it to 0.
- Send 0x3C with stop bit 0 and hold the line low for 3 bit times, then send 0x11.
  - `frame_err`=1 and no push for 0x3C.
  - 0x11 is received correctly only after the line returns high.
- Send 5 good frames (0x10–0x14) with `rx_ready`=0.
  - `level`=4 and `overrun`=1.
  - Pops return 0x10, 0x11, 0x12, 0x13 in order.
  - Repeat with `rx_ready`=1 held during the 5th stop sample: no overrun.
- Assert `reset_n`=0 midway through a DATA bit.
  - All outputs take their reset values immediately.
  - The next clean frame, 0x5A, is received correctly.
  - With `UART_RX_MAJORITY_EN` defined, a 1-cycle glitch at a mid-bit sample does not corrupt 0x5A.
